parity_seq_ctrl: RTL and testbench
==================================

// Module: parity_seq_ctrl
// PURPOSE
//  Round-robin scheduler that shares one narrow XOR-reduction (parity) unit among NUM_REQ requesters.
//  Each granted DATA_WIDTH word is fed through the unit CHUNK_WIDTH bits per cycle.
//  Partial parities are accumulated; the final bit is returned with the requester ID.
//  Sits between the parity/reduction datapath and the blocks that need word parity.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=1)
//  DATA_WIDTH  32  bits per request word; must be an integer multiple of CHUNK_WIDTH
//  CHUNK_WIDTH 8   bits reduced per cycle by the shared unit
//  derived: NUM_CHUNKS = DATA_WIDTH/CHUNK_WIDTH; ID_W = max(1, clog2(NUM_REQ))
// PORTS
//  clock      in   1                    single clock, rising edge
//  resetN     in   1                    asynchronous, active-low reset
//  reqValid   in   NUM_REQ              per-requester request valid
//  reqReady   out  NUM_REQ              per-requester accept strobe (one-hot or zero)
//  reqData    in   NUM_REQ*DATA_WIDTH   requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//  resValid   out  1                    result valid
//  resReady   in   1                    result consumer ready
//  resParity  out  1                    parity (XOR of all word bits)
//  resId      out  ID_W                 index of the requester that owns the result
// BEHAVIOUR
//  Reset (resetN=0, async): state=IDLE; reqReady=0, resValid=0, resParity=0, resId=0.
//   Accumulator, chunk count and shift register cleared; grant pointer=NUM_REQ-1, so requester 0 wins first.
//   Reset mid-operation aborts the transaction silently; no result is produced.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: if any reqValid, grant g = first valid index after the pointer, wrapping.
//   reqReady[g]=1 combinationally in that cycle.
//   Rising edge: capture word g into shift reg, acc=0, cnt=0, resId<=g, pointer<=g, state=RUN.
//   With no reqValid, stay in IDLE and keep reqReady=0.
//  RUN: each cycle acc ^= ^shift[CHUNK_WIDTH-1:0]; shift >>= CHUNK_WIDTH; cnt++.
//   When cnt==NUM_CHUNKS-1: resParity <= acc ^ chunk parity; resValid<=1; state=DONE.
//   reqReady=0 throughout.
//  DONE: resValid, resParity, resId held stable until resValid&&resReady.
//   On that handshake edge: resValid<=0, state=IDLE. No new grant in DONE.
//  Latency: resValid rises NUM_CHUNKS+1 cycles after the accept cycle.
//   Throughput is 1 word per NUM_CHUNKS+2 cycles when resReady is held high.
//  Requesters hold reqValid/reqData until reqReady; reqValid deasserted before grant is simply not served.
//  NUM_CHUNKS=1: RUN lasts exactly one cycle. NUM_REQ=1: resId is always 0, and the pointer is a constant.
//  All-zero word -> parity 0. Counter width = max(1, clog2(NUM_CHUNKS)); no wrap beyond NUM_CHUNKS-1.
// CONFIGURATION
//  PARITY_SEQ_ODD_EN defined: resParity = ~(XOR of word), i.e. odd parity; an all-zero word yields 1.
//  PARITY_SEQ_ODD_EN undefined: even parity as above. Timing and handshake are identical in both builds.
// STRUCTURE
//  Package parity_seq_pkg holds:
//   - state enum (IDLE, RUN, DONE)
//   - clog2 helper
//   - ID_W/NUM_CHUNKS derivation functions
//  Sub-module parity_chunk: combinational CHUNK_WIDTH-bit XOR reduction; exactly one instance (the shared unit).
//  Round-robin arbiter and FSM live in parity_seq_ctrl itself.
// TESTING (NUM_REQ=4, DATA_WIDTH=32, CHUNK_WIDTH=8, resReady=1 unless stated)
//  1. Only req0 valid, data 0x00000001 -> reqReady[0] for 1 cycle; 5 cycles later resValid=1, resParity=1, resId=0.
//  2. req0..3 valid together, data 0xFFFFFFFF, 0x00000003, 0x00000007, 0x00000000.
//     -> served in order 0,1,2,3 with parities 0,0,1,0.
//  3. resReady=0 for 10 cycles in DONE -> resValid/resParity/resId stable, reqReady stays 0.
//     Release -> IDLE next cycle.
//  4. resetN pulsed low during RUN -> all outputs 0 immediately. After release with req2 valid:
//     grant goes to req2, result correct, no stale result emitted.
//  5. req0 and req2 valid continuously -> grants alternate 0,2,0,2; req1/req3 reqReady never asserted.
//  6. PARITY_SEQ_ODD_EN defined, req0 data 0x00000000 -> resParity=1; data 0x00000001 -> resParity=0.

Source files
------------

// File: rtl/parity_seq_pkg.sv
// Shared types and elaboration-time helpers for the parity sequencer.
// Provides the FSM state enum and the width derivations used by parity_seq_ctrl.
package parity_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int calc_id_w(input int num_req);
    return (num_req > 1) ? clog2(num_req) : 1;
  endfunction

  function automatic int calc_num_chunks(input int data_width, input int chunk_width);
    return data_width / chunk_width;
  endfunction

  // The chunk counter is at least one bit wide, even with a single chunk.
  function automatic int calc_cnt_w(input int num_chunks);
    return (num_chunks > 1) ? clog2(num_chunks) : 1;
  endfunction

endpackage

// File: rtl/parity_chunk.sv
// Combinational XOR reduction of one CHUNK_WIDTH-bit slice.
// This is the single reduction unit time-shared by all requesters.
module parity_chunk #(
  parameter int CHUNK_WIDTH = 8
) (
  input  logic [CHUNK_WIDTH-1:0] data_in,
  output logic                   parity_out
);

  assign parity_out = ^data_in;

endmodule

// File: rtl/parity_seq_ctrl.sv
// Round-robin scheduler feeding granted words chunk-by-chunk through one shared parity unit.
// Define PARITY_SEQ_ODD_EN to report odd parity instead of even parity.
module parity_seq_ctrl
  import parity_seq_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8,
  localparam int ID_W       = calc_id_w(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic [NUM_REQ-1:0]            reqValid,
  output logic [NUM_REQ-1:0]            reqReady,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  output logic                          resValid,
  input  logic                          resReady,
  output logic                          resParity,
  output logic [ID_W-1:0]               resId
);

  localparam int NUM_CHUNKS = calc_num_chunks(DATA_WIDTH, CHUNK_WIDTH);
  localparam int CNT_W      = calc_cnt_w(NUM_CHUNKS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);
  localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(NUM_REQ - 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [ID_W-1:0]         res_id_q, res_id_d;
  logic                    res_valid_q, res_valid_d;
  logic                    res_parity_q, res_parity_d;

  logic                    grant_found;
  logic [ID_W-1:0]         grant_idx;
  logic                    chunk_par;
  logic                    final_par;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found && reqValid[(int'(ptr_q) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    reqReady = '0;
    if (resetN && (state_q == IDLE) && grant_found) reqReady[grant_idx] = 1'b1;
  end

  parity_chunk #(
    .CHUNK_WIDTH (CHUNK_WIDTH)
  ) u_parity_chunk (
    .data_in    (shift_q[CHUNK_WIDTH-1:0]),
    .parity_out (chunk_par)
  );

`ifdef PARITY_SEQ_ODD_EN
  assign final_par = ~(acc_q ^ chunk_par);
`else
  assign final_par = acc_q ^ chunk_par;
`endif

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    res_id_d     = res_id_q;
    res_valid_d  = res_valid_q;
    res_parity_d = res_parity_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          shift_d  = reqData[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          acc_d    = 1'b0;
          cnt_d    = '0;
          res_id_d = grant_idx;
          ptr_d    = grant_idx;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_q ^ chunk_par;
        shift_d = shift_q >> CHUNK_WIDTH;
        if (cnt_q == LAST_CNT) begin
          res_parity_d = final_par;
          res_valid_d  = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (resReady) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      ptr_q        <= PTR_INIT;
      res_id_q     <= '0;
      res_valid_q  <= 1'b0;
      res_parity_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      res_id_q     <= res_id_d;
      res_valid_q  <= res_valid_d;
      res_parity_q <= res_parity_d;
    end
  end

  assign resValid  = res_valid_q;
  assign resParity = res_parity_q;
  assign resId     = res_id_q;

endmodule

// File: tb/tb_parity_seq_ctrl.sv
// Self-checking bench for parity_seq_ctrl: directed scenarios followed by randomized traffic,
// compared against a ones-count parity model and a round-robin grant model.
module tb_parity_seq_ctrl;

  localparam int NUM_REQ     = 4;
  localparam int DATA_WIDTH  = 32;
  localparam int CHUNK_WIDTH = 8;
  localparam int NUM_CHUNKS  = DATA_WIDTH / CHUNK_WIDTH;

  logic                          clock = 1'b0;
  logic                          resetN;
  logic [NUM_REQ-1:0]            reqValid;
  logic [NUM_REQ-1:0]            reqReady;
  logic [NUM_REQ*DATA_WIDTH-1:0] reqData;
  logic                          resValid;
  logic                          resReady;
  logic                          resParity;
  logic [1:0]                    resId;

  int assertCount = 0;
  int failCount   = 0;

  logic            pendValid [NUM_REQ];
  logic [31:0]     pendData  [NUM_REQ];
  int              modelPtr;
  bit              holdValid;

  always #5 clock = ~clock;

  parity_seq_ctrl #(
    .NUM_REQ     (NUM_REQ),
    .DATA_WIDTH  (DATA_WIDTH),
    .CHUNK_WIDTH (CHUNK_WIDTH)
  ) dut (
    .clock     (clock),
    .resetN    (resetN),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqData   (reqData),
    .resValid  (resValid),
    .resReady  (resReady),
    .resParity (resParity),
    .resId     (resId)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Parity straight from the definition: count the ones in the word.
  function automatic logic modelParity(input logic [31:0] word);
    int ones;
    ones = $countones(word);
`ifdef PARITY_SEQ_ODD_EN
    return (ones % 2) == 0;
`else
    return (ones % 2) == 1;
`endif
  endfunction

  function automatic int modelGrant();
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (pendValid[(modelPtr + k) % NUM_REQ]) return (modelPtr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] randomWord();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1 << $urandom_range(0, 31);
      default: return $urandom();
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      reqValid[i] = pendValid[i];
      reqData[i*DATA_WIDTH +: DATA_WIDTH] = pendData[i];
    end
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic arrive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pendValid[i] && $urandom_range(0, 3) == 0) begin
        pendValid[i] = 1'b1;
        pendData[i]  = randomWord();
      end
    end
  endtask

  task automatic resetDut();
    resetN = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pendValid[i] = 1'b0;
      pendData[i]  = '0;
    end
    modelPtr = NUM_REQ - 1;
    applyStimulus();
    nextCycle();
    nextCycle();
    checkOutput("rst_resValid", resValid, 0);
    checkOutput("rst_resParity", resParity, 0);
    checkOutput("rst_resId", resId, 0);
    checkOutput("rst_reqReady", reqReady, 0);
    resetN = 1'b1;
    #1;
  endtask

  // Called in an IDLE cycle with at least one request pending; returns in the following IDLE cycle.
  task automatic serveOne(input int stallCycles, input bit randomArrivals);
    int          g;
    logic [31:0] word;
    logic        expPar;
    g = modelGrant();
    checkOutput("idle_resValid", resValid, 0);
    if (g < 0) begin
      checkOutput("idle_reqReady", reqReady, 0);
      return;
    end
    checkOutput("grant", reqReady, 32'h1 << g);
    word   = pendData[g];
    expPar = modelParity(word);
    nextCycle();
    modelPtr = g;
    if (holdValid) pendData[g] = randomWord();
    else           pendValid[g] = 1'b0;
    if (randomArrivals) arrive();
    applyStimulus();
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      checkOutput("run_resValid", resValid, 0);
      checkOutput("run_reqReady", reqReady, 0);
      nextCycle();
      if (randomArrivals) arrive();
      applyStimulus();
    end
    checkOutput("res_valid", resValid, 1);
    checkOutput("res_parity", resParity, expPar);
    checkOutput("res_id", resId, g);
    if (stallCycles > 0) begin
      resReady = 1'b0;
      for (int s = 0; s < stallCycles; s++) begin
        nextCycle();
        if (randomArrivals) arrive();
        applyStimulus();
        checkOutput("stall_resValid", resValid, 1);
        checkOutput("stall_resParity", resParity, expPar);
        checkOutput("stall_resId", resId, g);
        checkOutput("stall_reqReady", reqReady, 0);
      end
      resReady = 1'b1;
    end
    nextCycle();
    if (randomArrivals) arrive();
    applyStimulus();
    checkOutput("post_resValid", resValid, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (modelGrant() >= 0) serveOne(0, 1'b0);
    end
  endtask

  initial begin
    resReady  = 1'b1;
    holdValid = 1'b0;
    reqValid  = '0;
    reqData   = '0;
    resetDut();

    // Single requester with a one-bit word.
    pendValid[0] = 1'b1;
    pendData[0]  = 32'h0000_0001;
    applyStimulus();
    serveOne(0, 1'b0);

    // All four at once from a fresh pointer: served 0,1,2,3.
    resetDut();
    pendValid[0] = 1'b1; pendData[0] = 32'hFFFF_FFFF;
    pendValid[1] = 1'b1; pendData[1] = 32'h0000_0003;
    pendValid[2] = 1'b1; pendData[2] = 32'h0000_0007;
    pendValid[3] = 1'b1; pendData[3] = 32'h0000_0000;
    applyStimulus();
    for (int t = 0; t < NUM_REQ; t++) serveOne(0, 1'b0);

    // Consumer back-pressure for ten cycles while new requests arrive.
    pendValid[1] = 1'b1;
    pendData[1]  = randomWord();
    applyStimulus();
    serveOne(10, 1'b1);
    drain();

    // Reset in the middle of a transaction.
    for (int i = 0; i < NUM_REQ; i++) pendValid[i] = 1'b0;
    pendValid[3] = 1'b1;
    pendData[3]  = 32'h1234_5678;
    applyStimulus();
    checkOutput("abort_grant", reqReady, 32'h8);
    nextCycle();
    pendValid[3] = 1'b0;
    pendValid[2] = 1'b1;
    pendData[2]  = 32'h0000_0101;
    applyStimulus();
    nextCycle();
    resetN = 1'b0;
    #1;
    checkOutput("abort_resValid", resValid, 0);
    checkOutput("abort_resParity", resParity, 0);
    checkOutput("abort_resId", resId, 0);
    checkOutput("abort_reqReady", reqReady, 0);
    nextCycle();
    resetN   = 1'b1;
    modelPtr = NUM_REQ - 1;
    applyStimulus();
    serveOne(0, 1'b0);

    // Two requesters that never drop valid must alternate.
    holdValid    = 1'b1;
    pendValid[0] = 1'b1; pendData[0] = randomWord();
    pendValid[2] = 1'b1; pendData[2] = randomWord();
    applyStimulus();
    for (int t = 0; t < 4; t++) serveOne(0, 1'b0);
    holdValid = 1'b0;
    drain();

    // Randomized traffic with random consumer stalls.
    for (int t = 0; t < 30; t++) begin
      for (int w = 0; w < 50 && modelGrant() < 0; w++) begin
        checkOutput("wait_reqReady", reqReady, 0);
        nextCycle();
        arrive();
        applyStimulus();
      end
      if (modelGrant() < 0) begin
        pendValid[0] = 1'b1;
        pendData[0]  = randomWord();
        applyStimulus();
      end
      serveOne($urandom_range(0, 2), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
